// File: rtl/conv_mac_engine.sv
// Streaming convolution MAC: LANES-wide ifm x weight beats are summed over TAPS beats per neuron,
// scaled by FRAC, saturated to DW bits and packed PACK neurons per output word (first neuron at MSBs).
module conv_mac_engine #(
  parameter int LANES  = 4,
  parameter int DW     = 16,
  parameter int TAPS   = 9,
  parameter int PACK   = 4,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40,
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [15:0]         num_neurons,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] ifm,
  input  logic [LANES*DW-1:0] wgt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PACK*DW-1:0]  out_data,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                busy,
  output logic                done
);

  localparam int PCW = $clog2(PACK + 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;
  state_e state_q, state_d;

  logic [15:0]             numNeurons_q, nAccepted_q;
  logic [7:0]              tapCnt_q;
  logic                    s1Valid_q, s1First_q, s1Last_q;
  logic signed [2*DW-1:0]  prod_q [LANES];
  logic signed [ACC_W-1:0] acc_q;
  logic                    accDone_q;
  logic [PACK*DW-1:0]      packData_q, outData_q;
  logic [PCW-1:0]          packCnt_q;
  logic                    outValid_q;
  logic [ADDR_W-1:0]       outAddr_q;

  logic                    inReadyRaw, beatFire, lastTap, jobLastBeat, outFire, pipeEmpty;
  logic                    startAccept, busyRaw, doneRaw, packFull, flushEmit;
  logic signed [ACC_W-1:0] laneSum, shifted;
  logic [DW-1:0]           satRes;
  logic [PACK*DW-1:0]      packNext;

  assign inReadyRaw  = (state_q == RUN) && !outValid_q && (nAccepted_q < numNeurons_q);
  assign beatFire    = inReadyRaw && in_valid;
  assign lastTap     = (tapCnt_q == 8'(TAPS - 1));
  assign jobLastBeat = beatFire && lastTap && (nAccepted_q == numNeurons_q - 16'd1);
  assign outFire     = outValid_q && out_ready;
  assign pipeEmpty   = !s1Valid_q && !accDone_q;
  assign packFull    = accDone_q && (packCnt_q == PCW'(PACK - 1));
  assign flushEmit   = (state_q == FLUSH) && pipeEmpty && (packCnt_q != '0) && !outValid_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // The job ends only once the pipeline is drained and the last word has been taken.
  always_comb begin
    state_d     = state_q;
    startAccept = 1'b0;
    busyRaw     = 1'b0;
    doneRaw     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          startAccept = 1'b1;
          state_d     = (num_neurons == 16'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        busyRaw = 1'b1;
        if (jobLastBeat) state_d = FLUSH;
      end
      FLUSH: begin
        busyRaw = 1'b1;
        if (pipeEmpty && (packCnt_q == '0) && outFire) state_d = DONE;
      end
      DONE: begin
        doneRaw = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      numNeurons_q <= '0;
      nAccepted_q  <= '0;
      tapCnt_q     <= '0;
    end else if (startAccept) begin
      numNeurons_q <= num_neurons;
      nAccepted_q  <= '0;
      tapCnt_q     <= '0;
    end else if (beatFire) begin
      if (lastTap) begin
        tapCnt_q    <= '0;
        nAccepted_q <= nAccepted_q + 16'd1;
      end else begin
        tapCnt_q <= tapCnt_q + 8'd1;
      end
    end
  end

  // Products at E+1, accumulate at E+2; a neuron's first beat loads so neurons run back to back.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1First_q <= 1'b0;
      s1Last_q  <= 1'b0;
      accDone_q <= 1'b0;
      acc_q     <= '0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else begin
      s1Valid_q <= beatFire;
      if (beatFire) begin
        s1First_q <= (tapCnt_q == 8'd0);
        s1Last_q  <= lastTap;
        for (int i = 0; i < LANES; i++)
          prod_q[i] <= (2*DW)'($signed(ifm[(LANES-1-i)*DW +: DW])) *
                       (2*DW)'($signed(wgt[(LANES-1-i)*DW +: DW]));
      end
      accDone_q <= s1Valid_q && s1Last_q;
      if (s1Valid_q) acc_q <= s1First_q ? laneSum : acc_q + laneSum;
    end
  end

  always_comb begin
    laneSum = '0;
    for (int i = 0; i < LANES; i++) laneSum = laneSum + ACC_W'(prod_q[i]);
  end

  always_comb begin
    shifted = acc_q >>> FRAC;
    if (shifted > SAT_MAX)      satRes = {1'b0, {(DW-1){1'b1}}};
    else if (shifted < SAT_MIN) satRes = {1'b1, {(DW-1){1'b0}}};
    else                        satRes = shifted[DW-1:0];
    packNext = packData_q;
    for (int k = 0; k < PACK; k++)
      if (packCnt_q == PCW'(k)) packNext[(PACK-1-k)*DW +: DW] = satRes;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      packData_q <= '0;
      packCnt_q  <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outAddr_q  <= '0;
    end else if (startAccept) begin
      packData_q <= '0;
      packCnt_q  <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outAddr_q  <= '0;
    end else begin
      if (outFire) begin
        outValid_q <= 1'b0;
        outAddr_q  <= outAddr_q + 1'b1;
      end
      if (packFull) begin
        outValid_q <= 1'b1;
        outData_q  <= packNext;
        packData_q <= '0;
        packCnt_q  <= '0;
      end else if (accDone_q) begin
        packData_q <= packNext;
        packCnt_q  <= packCnt_q + 1'b1;
      end else if (flushEmit) begin
        outValid_q <= 1'b1;
        outData_q  <= packData_q;
        packData_q <= '0;
        packCnt_q  <= '0;
      end
    end
  end

  assign in_ready  = inReadyRaw && !rst;
  assign out_valid = outValid_q && !rst;
  assign out_data  = rst ? '0 : outData_q;
  assign out_addr  = rst ? '0 : outAddr_q;
  assign busy      = busyRaw && !rst;
  assign done      = doneRaw && !rst;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Randomized bench for conv_mac_engine (TAPS=3) with a plain-arithmetic reference model of
// neuron sums, scaling, saturation and MSB-first packing.
module tb_conv_mac_engine;

  localparam int LANES  = 4;
  localparam int DW     = 16;
  localparam int TAPS   = 3;
  localparam int PACK   = 4;
  localparam int FRAC   = 8;
  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [15:0] num_neurons, out_addr;
  logic [63:0] ifm, wgt, out_data;

  int errors = 0;
  int checks = 0;

  logic [63:0] beatIfm[$], beatWgt[$], gotData[$], expData[$];
  logic [15:0] gotAddr[$], expAddr[$];
  bit timedOut;
  int doneCycle, holdViol, protoViol, validCycles, beatsTaken;

  always #5 clk = ~clk;

  conv_mac_engine #(.LANES(LANES), .DW(DW), .TAPS(TAPS), .PACK(PACK), .FRAC(FRAC),
                    .ACC_W(40), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .num_neurons(num_neurons),
    .in_valid(in_valid), .in_ready(in_ready), .ifm(ifm), .wgt(wgt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .busy(busy), .done(done)
  );

  task automatic fillBeats(input int nBeats, input logic [63:0] f, input logic [63:0] w);
    beatIfm.delete();
    beatWgt.delete();
    repeat (nBeats) begin
      beatIfm.push_back(f);
      beatWgt.push_back(w);
    end
  endtask

  task automatic randBeats(input int nBeats, input int span);
    logic [63:0] f, w;
    int v;
    beatIfm.delete();
    beatWgt.delete();
    repeat (nBeats) begin
      for (int l = 0; l < LANES; l++) begin
        v = int'($urandom_range(2 * span)) - span;
        f[(LANES-1-l)*DW +: DW] = 16'(v);
        v = int'($urandom_range(2 * span)) - span;
        w[(LANES-1-l)*DW +: DW] = 16'(v);
      end
      beatIfm.push_back(f);
      beatWgt.push_back(w);
    end
  endtask

  // Reference: each neuron is the floor-scaled, clamped dot product of its TAPS beats.
  task automatic buildExpected(input int n);
    longint acc, res;
    logic [63:0] fv, wv, word;
    logic [15:0] fl, wl;
    int nw, j;
    expData.delete();
    expAddr.delete();
    nw = (n + PACK - 1) / PACK;
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int k = 0; k < PACK; k++) begin
        j = w * PACK + k;
        if (j < n) begin
          acc = 0;
          for (int t = 0; t < TAPS; t++) begin
            fv = beatIfm[j*TAPS+t];
            wv = beatWgt[j*TAPS+t];
            for (int l = 0; l < LANES; l++) begin
              fl = fv[(LANES-1-l)*DW +: DW];
              wl = wv[(LANES-1-l)*DW +: DW];
              acc += longint'($signed(fl)) * longint'($signed(wl));
            end
          end
          res = acc >>> FRAC;
          if (res > 32767) res = 32767;
          else if (res < -32768) res = -32768;
          word[(PACK-1-k)*DW +: DW] = 16'(res);
        end
      end
      expData.push_back(word);
      expAddr.push_back(16'(w));
    end
  endtask

  // Drives one job and records what the DUT emits; verdicts are left to the calling test.
  task automatic runJob(input int n, input int validPct, input int readyPct,
                        input int holdFirst, input int restartAt);
    int idx, holdLeft;
    bit prevHeld, fire, ofire;
    logic [63:0] prevData;
    logic [15:0] prevAddr;
    gotData.delete();
    gotAddr.delete();
    timedOut = 0; doneCycle = -1; holdViol = 0; protoViol = 0; validCycles = 0;
    idx = 0; holdLeft = holdFirst; prevHeld = 0; prevData = '0; prevAddr = '0;
    @(negedge clk);
    start = 1'b1; num_neurons = 16'(n); in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      start = (cyc == restartAt);
      if (start) num_neurons = 16'd1;
      in_valid = (idx < n * TAPS) && ($urandom_range(99) < validPct);
      if (in_valid) begin
        ifm = beatIfm[idx];
        wgt = beatWgt[idx];
      end else begin
        ifm = {$urandom, $urandom};
        wgt = {$urandom, $urandom};
      end
      if (out_valid && holdLeft > 0) begin
        out_ready = 1'b0;
        holdLeft--;
      end else begin
        out_ready = ($urandom_range(99) < readyPct);
      end
      #1;
      if (prevHeld && (!out_valid || out_data !== prevData || out_addr !== prevAddr)) holdViol++;
      if (out_valid && in_ready) protoViol++;
      if (out_valid) validCycles++;
      fire  = in_valid && in_ready;
      ofire = out_valid && out_ready;
      prevHeld = out_valid && !out_ready;
      prevData = out_data;
      prevAddr = out_addr;
      if (ofire) begin
        gotData.push_back(out_data);
        gotAddr.push_back(out_addr);
      end
      if (fire) idx++;
      if (done) begin
        doneCycle = cyc;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    beatsTaken = idx;
    if (doneCycle < 0) timedOut = 1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; num_neurons = 16'd5; in_valid = 1'b1; out_ready = 1'b1;
    ifm = {$urandom, $urandom}; wgt = {$urandom, $urandom};
    repeat (2) @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (out_addr !== 16'h0) begin errors++; $display("[TB] FAIL reset_out_addr: got %h expected 0", out_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unit_sum;
    fillBeats(12, {4{16'h0100}}, {4{16'h0100}});
    runJob(4, 100, 100, 0, -1);
    checks++; if (timedOut) begin errors++; $display("[TB] FAIL unit_done: no done within %0d cycles", BUDGET); end
    checks++; if (gotData.size() != 1) begin errors++; $display("[TB] FAIL unit_words: got %0d expected 1", gotData.size()); end
    if (gotData.size() >= 1) begin
      checks++; if (gotData[0] !== 64'h0C00_0C00_0C00_0C00) begin errors++; $display("[TB] FAIL unit_data: got %h expected 0c000c000c000c00", gotData[0]); end
      checks++; if (gotAddr[0] !== 16'd0) begin errors++; $display("[TB] FAIL unit_addr: got %0d expected 0", gotAddr[0]); end
    end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL unit_after_done: got busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_saturation;
    fillBeats(3, {4{16'h7FFF}}, {4{16'h7FFF}});
    repeat (3) begin
      beatIfm.push_back({4{16'h8000}});
      beatWgt.push_back({4{16'h7FFF}});
    end
    runJob(2, 100, 100, 0, -1);
    checks++; if (timedOut || gotData.size() != 1) begin errors++; $display("[TB] FAIL sat_words: got %0d words timeout=%0d expected 1 word", gotData.size(), timedOut); end
    if (gotData.size() >= 1) begin
      checks++; if (gotData[0] !== 64'h7FFF_8000_0000_0000) begin errors++; $display("[TB] FAIL sat_data: got %h expected 7fff800000000000", gotData[0]); end
    end
  endtask

  task automatic test_partial_pack;
    fillBeats(15, {4{16'h0100}}, {4{16'h0100}});
    runJob(5, 100, 100, 0, -1);
    checks++; if (timedOut || gotData.size() != 2) begin errors++; $display("[TB] FAIL partial_words: got %0d words timeout=%0d expected 2", gotData.size(), timedOut); end
    if (gotData.size() >= 2) begin
      checks++; if (gotData[0] !== 64'h0C00_0C00_0C00_0C00 || gotAddr[0] !== 16'd0) begin errors++; $display("[TB] FAIL partial_word0: got %h@%0d expected 0c000c000c000c00@0", gotData[0], gotAddr[0]); end
      checks++; if (gotData[1] !== 64'h0C00_0000_0000_0000 || gotAddr[1] !== 16'd1) begin errors++; $display("[TB] FAIL partial_word1: got %h@%0d expected 0c00000000000000@1", gotData[1], gotAddr[1]); end
    end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL partial_busy: got %b expected 0", busy); end
  endtask

  task automatic test_backpressure;
    fillBeats(12, {4{16'h0100}}, {4{16'h0100}});
    runJob(4, 100, 100, 10, -1);
    checks++; if (timedOut) begin errors++; $display("[TB] FAIL bp_done: no done within %0d cycles", BUDGET); end
    checks++; if (beatsTaken != 12) begin errors++; $display("[TB] FAIL bp_beats: got %0d expected 12", beatsTaken); end
    checks++; if (holdViol != 0) begin errors++; $display("[TB] FAIL bp_hold: got %0d unstable cycles expected 0", holdViol); end
    checks++; if (protoViol != 0) begin errors++; $display("[TB] FAIL bp_in_ready: got %0d cycles with in_ready during out_valid expected 0", protoViol); end
    checks++; if (validCycles != 11) begin errors++; $display("[TB] FAIL bp_valid_cycles: got %0d expected 11", validCycles); end
    checks++; if (gotData.size() != 1 || (gotData.size() == 1 && gotData[0] !== 64'h0C00_0C00_0C00_0C00)) begin
      errors++; $display("[TB] FAIL bp_data: got %0d words first=%h expected 1 word 0c000c000c000c00", gotData.size(), (gotData.size() > 0) ? gotData[0] : 64'h0);
    end
  endtask

  task automatic test_mid_reset;
    fillBeats(12, {4{16'h0100}}, {4{16'h0100}});
    @(negedge clk);
    start = 1'b1; num_neurons = 16'd4;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; ifm = {4{16'h0100}}; wgt = {4{16'h0100}};
    repeat (4) @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ctrl: got busy=%b in_ready=%b done=%b expected 0 0 0", busy, in_ready, done); end
    checks++; if (out_valid !== 1'b0 || out_data !== 64'h0 || out_addr !== 16'h0) begin errors++; $display("[TB] FAIL midrst_out: got v=%b d=%h a=%h expected zeros", out_valid, out_data, out_addr); end
    randBeats(12, 300);
    buildExpected(4);
    runJob(4, 80, 80, 0, -1);
    checks++; if (timedOut || gotData.size() != expData.size()) begin errors++; $display("[TB] FAIL midrst_words: got %0d expected %0d timeout=%0d", gotData.size(), expData.size(), timedOut); end
    for (int i = 0; i < gotData.size() && i < expData.size(); i++) begin
      checks++; if (gotData[i] !== expData[i] || gotAddr[i] !== expAddr[i]) begin errors++; $display("[TB] FAIL midrst_word%0d: got %h@%0d expected %h@%0d", i, gotData[i], gotAddr[i], expData[i], expAddr[i]); end
    end
  endtask

  task automatic test_zero_and_busy_start;
    runJob(0, 100, 100, 0, -1);
    checks++; if (doneCycle != 0) begin errors++; $display("[TB] FAIL zero_done_latency: got %0d expected 0", doneCycle); end
    checks++; if (validCycles != 0 || gotData.size() != 0) begin errors++; $display("[TB] FAIL zero_no_output: got %0d valid cycles expected 0", validCycles); end
    fillBeats(12, {4{16'h0100}}, {4{16'h0100}});
    runJob(4, 100, 100, 0, 3);
    checks++; if (timedOut || beatsTaken != 12) begin errors++; $display("[TB] FAIL busy_start_beats: got %0d expected 12", beatsTaken); end
    checks++; if (gotData.size() != 1 || (gotData.size() == 1 && (gotData[0] !== 64'h0C00_0C00_0C00_0C00 || gotAddr[0] !== 16'd0))) begin
      errors++; $display("[TB] FAIL busy_start_data: got %0d words first=%h expected 1 word 0c000c000c000c00", gotData.size(), (gotData.size() > 0) ? gotData[0] : 64'h0);
    end
  endtask

  task automatic test_random;
    int n, span;
    for (int job = 0; job < 6; job++) begin
      n = $urandom_range(11, 1);
      span = (job % 3 == 0) ? 300 : ((job % 3 == 1) ? 3000 : 32768);
      randBeats(n * TAPS, span);
      buildExpected(n);
      runJob(n, 60, 50, 0, -1);
      checks++; if (timedOut || gotData.size() != expData.size()) begin errors++; $display("[TB] FAIL rand%0d_words: got %0d expected %0d timeout=%0d", job, gotData.size(), expData.size(), timedOut); end
      checks++; if (holdViol != 0 || protoViol != 0 || beatsTaken != n * TAPS) begin errors++; $display("[TB] FAIL rand%0d_proto: got hold=%0d inready=%0d beats=%0d expected 0 0 %0d", job, holdViol, protoViol, beatsTaken, n * TAPS); end
      for (int i = 0; i < gotData.size() && i < expData.size(); i++) begin
        checks++; if (gotData[i] !== expData[i] || gotAddr[i] !== expAddr[i]) begin errors++; $display("[TB] FAIL rand%0d_word%0d: got %h@%0d expected %h@%0d", job, i, gotData[i], gotAddr[i], expData[i], expAddr[i]); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_neurons = '0; in_valid = 1'b0; out_ready = 1'b0;
    ifm = '0; wgt = '0;
    test_reset();
    test_unit_sum();
    test_saturation();
    test_partial_pack();
    test_backpressure();
    test_mid_reset();
    test_zero_and_busy_start();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
